// File: rtl/ecc_sequencer_if.sv
// Bus bundle for ecc_sequencer: job request, data memory port, ALU port, status.
// The err_cnt signal exists only when ECC_ERRCNT_EN is defined.
interface ecc_sequencer_if;
    // job request
    logic       start;
    logic       mode;
    logic [7:0] src_base;
    logic [7:0] dst_base;
    logic [7:0] count;
    // data memory
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    // ALU
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_out;
    // status
    logic       busy;
    logic       done;
`ifdef ECC_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    // sequencer side
    modport master (
        input  start, mode, src_base, dst_base, count, mem_rd_data, alu_out,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output alu_a, alu_b, alu_ctrl, busy, done
`ifdef ECC_ERRCNT_EN
        , output err_cnt
`endif
    );

    // environment side (requester, memory, ALU)
    modport slave (
        output start, mode, src_base, dst_base, count, mem_rd_data, alu_out,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  alu_a, alu_b, alu_ctrl, busy, done
`ifdef ECC_ERRCNT_EN
        , input err_cnt
`endif
    );
endinterface

// File: rtl/ecc_sequencer.sv
// ecc_sequencer: walks Count byte pairs from SrcBase, runs each pair through the
// external ALU (encode or decode/correct) and writes the result pair to DstBase.
// Five cycles per pair: RD_LO, RD_HI, LAT_HI, WR_HI, WR_LO.
// Optional feature: define ECC_ERRCNT_EN to add the err_cnt output (count of
// decode pairs that the ALU changed).
module ecc_sequencer (
    input  logic                clk,
    input  logic                rst_n,
    ecc_sequencer_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        LAT_HI = 3'd3,
        WR_HI  = 3'd4,
        WR_LO  = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ENC_HI = 4'b0100;
    localparam logic [3:0] OP_ENC_LO = 4'b0101;
    localparam logic [3:0] OP_DEC_HI = 4'b0110;
    localparam logic [3:0] OP_DEC_LO = 4'b0111;

    state_t     state, state_nxt;
    logic [7:0] src_q, dst_q, cnt_q;
    logic       mode_q;
    logic [7:0] idx;
    logic [7:0] lo_q, hi_q;
    logic       done_q;
    logic [7:0] pair_off;
    logic [7:0] src_addr, dst_addr;
    logic       last_pair;
    logic       accept;

`ifdef ECC_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       hi_err_q;
`endif

    // byte offset of the current pair; all address math wraps mod 256
    assign pair_off  = {idx[6:0], 1'b0};
    assign src_addr  = src_q + pair_off;
    assign dst_addr  = dst_q + pair_off;
    assign last_pair = (idx == cnt_q - 8'd1);
    assign accept    = (state == IDLE) && bus.start;

    assign bus.busy  = (state != IDLE);
    // Done is registered off the DONE state, so the pulse lands one cycle after
    // the DONE state itself (while the FSM is already back in IDLE).
    assign bus.done  = done_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and all bus outputs; everything idles at zero outside its state
    always_comb begin
        state_nxt       = state;
        bus.mem_addr    = 8'h00;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'h00;
        bus.alu_a       = 8'h00;
        bus.alu_b       = 8'h00;
        bus.alu_ctrl    = 4'b0000;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = (bus.count == 8'd0) ? DONE : RD_LO;
            end
            RD_LO: begin
                bus.mem_addr  = src_addr;
                bus.mem_rd_en = 1'b1;
                state_nxt     = RD_HI;
            end
            RD_HI: begin
                bus.mem_addr  = src_addr + 8'd1;
                bus.mem_rd_en = 1'b1;
                state_nxt     = LAT_HI;
            end
            LAT_HI: begin
                state_nxt = WR_HI;
            end
            WR_HI: begin
                bus.alu_a       = lo_q;
                bus.alu_b       = hi_q;
                bus.alu_ctrl    = mode_q ? OP_DEC_HI : OP_ENC_HI;
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = dst_addr + 8'd1;
                bus.mem_wr_data = bus.alu_out;
                state_nxt       = WR_LO;
            end
            WR_LO: begin
                bus.alu_a       = lo_q;
                bus.alu_b       = hi_q;
                bus.alu_ctrl    = mode_q ? OP_DEC_LO : OP_ENC_LO;
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = dst_addr;
                bus.mem_wr_data = bus.alu_out;
                state_nxt       = last_pair ? DONE : RD_LO;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // job parameters, pair index and captured bytes; params only load in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= 8'h00;
            dst_q  <= 8'h00;
            cnt_q  <= 8'h00;
            mode_q <= 1'b0;
            idx    <= 8'h00;
            lo_q   <= 8'h00;
            hi_q   <= 8'h00;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if (accept) begin
                src_q  <= bus.src_base;
                dst_q  <= bus.dst_base;
                cnt_q  <= bus.count;
                mode_q <= bus.mode;
                idx    <= 8'h00;
            end
            // both bytes are held before any write, so Src == Dst is safe
            if (state == RD_HI)  lo_q <= bus.mem_rd_data;
            if (state == LAT_HI) hi_q <= bus.mem_rd_data;
            if (state == WR_LO && !last_pair) idx <= idx + 8'd1;
        end
    end

`ifdef ECC_ERRCNT_EN
    assign bus.err_cnt = err_cnt_q;

    // count decode pairs the ALU altered; hi-byte mismatch is held into WR_LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
            hi_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                err_cnt_q <= 8'h00;
                hi_err_q  <= 1'b0;
            end
            if (state == WR_HI) hi_err_q <= mode_q && (bus.alu_out != hi_q);
            if (state == WR_LO && mode_q && (hi_err_q || bus.alu_out != lo_q)
                && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: doc/ecc_sequencer.md
ECC_SEQUENCER -- requirements
Module: ecc_sequencer

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: Reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Start  in  1  level-sampled request to begin a job.
REQ-004 SHALL have ports: Mode  in  1  0 = encode, 1 = decode/correct.
REQ-005 SHALL have ports: SrcBase  in  8  first source byte address.
REQ-006 SHALL have ports: DstBase  in  8  first destination byte address.
REQ-007 SHALL have ports: Count  in  8  number of 2-byte message pairs.
REQ-008 SHALL have ports: MemAddr  out  8  data memory address.
REQ-009 SHALL have ports: MemRdEn  out  1  memory read strobe; read data returns one cycle later.
REQ-010 SHALL have ports: MemRdData  in  8  memory read data.
REQ-011 SHALL have ports: MemWrEn  out  1  memory write strobe.
REQ-012 SHALL have ports: MemWrData  out  8  memory write data.
REQ-013 SHALL have ports: AluA / AluB  out  8 each  ALU operands, low byte on A, high byte on B.
REQ-014 SHALL have ports: AluCtrl  out  4  ALU opcode.
REQ-015 SHALL have ports: AluOut  in  8  ALU combinational result.
REQ-016 SHALL have ports: Busy  out  1  high in every state except IDLE.
REQ-017 SHALL have ports: Done  out  1  one-cycle completion pulse.

Function
REQ-018 SHALL have FSM states IDLE, RD_LO, RD_HI, LAT_HI, WR_HI, WR_LO, DONE.
REQ-019 In IDLE with Start=1: SHALL latch SrcBase, DstBase, Count and Mode, clear pair index i, and go to RD_LO; if Count=0, SHALL go straight to DONE.
REQ-020 RD_LO: MemAddr=Src+2i, MemRdEn=1, next state RD_HI.
REQ-021 RD_HI: MemAddr=Src+2i+1, MemRdEn=1, capture MemRdData into the lo register, next state LAT_HI.
REQ-022 LAT_HI: capture MemRdData into the hi register, next state WR_HI.
REQ-023 WR_HI: AluA=lo, AluB=hi, AluCtrl=0100 (encode) or 0110 (decode); MemWrEn=1, MemAddr=Dst+2i+1, MemWrData=AluOut; next state WR_LO.
REQ-024 WR_LO: AluCtrl=0101 (encode) or 0111 (decode); MemWrEn=1, MemAddr=Dst+2i, MemWrData=AluOut; if i=Count-1 go to DONE, else i++ and go to RD_LO.
REQ-025 DONE: Done=1 for exactly one cycle, then go to IDLE.
REQ-026 Each job SHALL take 5 cycles per pair; Done SHALL be high in the cycle after edge k+5N+1, where k is the Start-sampling edge.
REQ-027 Address arithmetic SHALL be 8-bit modulo 256, so addresses wrap from 0xFF to 0x00.
REQ-028 MemRdEn and MemWrEn SHALL never be high in the same cycle.
REQ-029 Start while Busy=1 SHALL be ignored, and the latched parameters SHALL not change mid-job.
REQ-030 In-place operation (Src=Dst) SHALL be correct: both bytes are captured before either write.
REQ-031 Outside WR_HI/WR_LO: AluA=AluB=0, AluCtrl=0000, MemWrData=0; MemAddr=0 when neither strobe is active.

Reset
REQ-032 Reset=0 SHALL immediately force IDLE and clear Busy, Done, MemRdEn, MemWrEn, MemAddr, MemWrData, AluA, AluB, AluCtrl, i, lo, hi and all latched parameters, even mid-job; no further write SHALL occur after assertion.
REQ-033 After deassertion the block SHALL wait in IDLE for Start.

Configuration
REQ-034 With ECC_ERRCNT_EN defined: SHALL add output ErrCnt (8 bits, reset 0, cleared on each accepted Start), incremented once per decode pair whose WR_HI or WR_LO AluOut differs from hi or lo respectively; it saturates at 0xFF and is unchanged in encode mode.
REQ-035 Without ECC_ERRCNT_EN: the ErrCnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Encode, Count=1, Src=0x10 holding {0x01, 0x00}, Dst=0x20 -> mem[0x21]=0x00, mem[0x20]=0x0F, Done 6 cycles after Start edge.
REQ-037 Decode, Count=1, {lo=0x01, hi=0x00} -> writes 0x00 to hi and 0x00 to lo; ErrCnt=1 when ECC_ERRCNT_EN is defined.
REQ-038 Decode, {0x00, 0x00} -> writes 0x00, 0x00; ErrCnt stays 0.
REQ-039 Count=0 -> no MemRdEn/MemWrEn pulses; Done pulses on the second cycle after the Start edge.
REQ-040 Count=2, Src=0xFE -> reads 0xFE, 0xFF, 0x00, 0x01 in order; Start pulses mid-job are ignored.
REQ-041 Reset asserted during WR_HI of pair 3 of 5 -> outputs clear asynchronously, no WR_LO write; a new Start runs a full job.
